// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus layouts, alu_op bit indices and
// memory access size encodings.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 158;
  localparam int ES_TO_MS_BUS_WD = 76;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_SLT   = 2;
  localparam int OP_SLTU  = 3;
  localparam int OP_AND   = 4;
  localparam int OP_NOR   = 5;
  localparam int OP_OR    = 6;
  localparam int OP_XOR   = 7;
  localparam int OP_SLL   = 8;
  localparam int OP_SRL   = 9;
  localparam int OP_SRA   = 10;
  localparam int OP_LUI   = 11;
  localparam int OP_MUL   = 12;
  localparam int OP_MULH  = 13;
  localparam int OP_MULHU = 14;
  localparam int OP_DIV   = 15;
  localparam int OP_MOD   = 16;
  localparam int OP_DIVU  = 17;
  localparam int OP_MODU  = 18;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  // One quotient bit per step of the iterative divider
  localparam logic [5:0] DIV_STEPS = 6'd32;

  typedef struct packed {
    logic [18:0] alu_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] rkd_value;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        gr_we;
    logic        mem_we;
    logic        res_from_mem;
    logic [1:0]  mem_size;
    logic        load_sign;
  } ds_to_es_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] es_result;
    logic [4:0]  dest;
    logic        gr_we;
    logic        res_from_mem;
    logic [1:0]  mem_size;
    logic        load_sign;
    logic [1:0]  addr_low;
  } es_to_ms_bus_t;

endpackage

// File: rtl/alu.sv
// Integer ALU with a multi-cycle restoring divider; div_delay counts the steps
// still outstanding and reaches 0 in the cycle the quotient/remainder is valid.
module alu
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result,
  output logic [5:0]  div_delay
);

  logic        div_busy_r, div_neg_q_r, div_neg_r_r;
  logic [5:0]  div_cnt_r;
  logic [31:0] div_rem_r, div_quo_r, div_dsr_r;
  logic        dividend_tvalid;
  logic        is_div_s, div_signed_s;
  logic [31:0] src1_abs_s, src2_abs_s, quo_fix_s, rem_fix_s, sra_s;
  logic [32:0] div_shift_s, div_diff_s;
  logic signed [63:0] mul_a_s, mul_b_s, mul_p_s;

  assign is_div_s        = |alu_op[OP_MODU:OP_DIV];
  assign div_signed_s    = alu_op[OP_DIV] | alu_op[OP_MOD];
  assign dividend_tvalid = is_div_s & ~div_busy_r;
  assign src1_abs_s      = (div_signed_s & alu_src1[31]) ? (32'd0 - alu_src1) : alu_src1;
  assign src2_abs_s      = (div_signed_s & alu_src2[31]) ? (32'd0 - alu_src2) : alu_src2;
  assign div_shift_s     = {div_rem_r, div_quo_r[31]};
  assign div_diff_s      = div_shift_s - {1'b0, div_dsr_r};
  assign quo_fix_s       = div_neg_q_r ? (32'd0 - div_quo_r) : div_quo_r;
  assign rem_fix_s       = div_neg_r_r ? (32'd0 - div_rem_r) : div_rem_r;

  // Start cycle reports one extra step so a fresh divide never looks finished
  always_comb begin
    div_delay = 6'd0;
    if (div_busy_r) begin
      div_delay = div_cnt_r;
    end else if (dividend_tvalid) begin
      div_delay = DIV_STEPS + 6'd1;
    end else begin
      div_delay = 6'd0;
    end
  end

  // Divider state: latch magnitudes on start, one restoring step per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      div_busy_r  <= 1'b0;
      div_cnt_r   <= 6'd0;
      div_rem_r   <= 32'd0;
      div_quo_r   <= 32'd0;
      div_dsr_r   <= 32'd0;
      div_neg_q_r <= 1'b0;
      div_neg_r_r <= 1'b0;
    end else if (dividend_tvalid) begin
      div_busy_r  <= 1'b1;
      div_cnt_r   <= DIV_STEPS;
      div_rem_r   <= 32'd0;
      div_quo_r   <= src1_abs_s;
      div_dsr_r   <= src2_abs_s;
      div_neg_q_r <= div_signed_s & (alu_src1[31] ^ alu_src2[31]);
      div_neg_r_r <= div_signed_s & alu_src1[31];
    end else if (div_busy_r && (div_cnt_r != 6'd0)) begin
      div_cnt_r <= div_cnt_r - 6'd1;
      if (!div_diff_s[32]) begin
        div_rem_r <= div_diff_s[31:0];
        div_quo_r <= {div_quo_r[30:0], 1'b1};
      end else begin
        div_rem_r <= div_shift_s[31:0];
        div_quo_r <= {div_quo_r[30:0], 1'b0};
      end
    end else if (div_busy_r) begin
      div_busy_r <= 1'b0;
    end else begin
      div_busy_r <= div_busy_r;
    end
  end

  assign sra_s   = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);
  assign mul_a_s = {{32{alu_op[OP_MULH] & alu_src1[31]}}, alu_src1};
  assign mul_b_s = {{32{alu_op[OP_MULH] & alu_src2[31]}}, alu_src2};
  assign mul_p_s = mul_a_s * mul_b_s;

  assign alu_result =
      ({32{alu_op[OP_ADD]}}  & (alu_src1 + alu_src2))
    | ({32{alu_op[OP_SUB]}}  & (alu_src1 - alu_src2))
    | ({32{alu_op[OP_SLT]}}  & {31'd0, $signed(alu_src1) < $signed(alu_src2)})
    | ({32{alu_op[OP_SLTU]}} & {31'd0, alu_src1 < alu_src2})
    | ({32{alu_op[OP_AND]}}  & (alu_src1 & alu_src2))
    | ({32{alu_op[OP_NOR]}}  & ~(alu_src1 | alu_src2))
    | ({32{alu_op[OP_OR]}}   & (alu_src1 | alu_src2))
    | ({32{alu_op[OP_XOR]}}  & (alu_src1 ^ alu_src2))
    | ({32{alu_op[OP_SLL]}}  & (alu_src1 << alu_src2[4:0]))
    | ({32{alu_op[OP_SRL]}}  & (alu_src1 >> alu_src2[4:0]))
    | ({32{alu_op[OP_SRA]}}  & sra_s)
    | ({32{alu_op[OP_LUI]}}  & alu_src2)
    | ({32{alu_op[OP_MUL]}}  & mul_p_s[31:0])
    | ({32{alu_op[OP_MULH] | alu_op[OP_MULHU]}} & mul_p_s[63:32])
    | ({32{alu_op[OP_DIV] | alu_op[OP_DIVU]}}   & quo_fix_s)
    | ({32{alu_op[OP_MOD] | alu_op[OP_MODU]}}   & rem_fix_s);

endmodule

// File: rtl/es_store_gen.sv
// Byte-lane write strobes and lane-replicated store data for the data SRAM.
module es_store_gen
  import exe_stage_pkg::*;
(
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [1:0]  addr_low,
  input  logic [31:0] rkd_value,
  output logic [3:0]  we,
  output logic [31:0] wdata
);

  logic [3:0] lane_mask_s;

  // Size-dependent lane mask and replicated data
  always_comb begin
    lane_mask_s = 4'b0000;
    wdata       = rkd_value;
    case (mem_size)
      MEM_BYTE: begin
        lane_mask_s = 4'b0001;
        wdata       = {4{rkd_value[7:0]}};
      end
      MEM_HALF: begin
        lane_mask_s = 4'b0011;
        wdata       = {2{rkd_value[15:0]}};
      end
      MEM_WORD: begin
        lane_mask_s = 4'b1111;
        wdata       = rkd_value;
      end
      default: begin
        lane_mask_s = 4'b0000;
        wdata       = rkd_value;
      end
    endcase
  end

  // Strobes only for stores; lanes shifted past bit 3 are dropped
  always_comb begin
    we = 4'b0000;
    if (mem_we) begin
      we = lane_mask_s << addr_low;
    end else begin
      we = 4'b0000;
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute pipeline stage: runs the ALU, holds divides until their result is
// captured, issues data SRAM requests and drives the EXE forwarding port.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_allowin,
  input  logic                       ms_allowin,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata,
  output logic                       es_fwd_valid,
  output logic                       es_fwd_is_load,
  output logic [4:0]                 es_fwd_dest,
  output logic [31:0]                es_fwd_data
);

  ds_to_es_bus_t es_bus_r;
  es_to_ms_bus_t es_to_ms_s;
  logic          es_valid_r, div_done_r;
  logic [31:0]   div_result_r;
  logic          es_ready_go_s, es_is_div_s;
  logic [18:0]   alu_op_s;
  logic [31:0]   alu_result_s, es_result_s;
  logic [5:0]    div_delay_s;

  assign es_is_div_s    = |es_bus_r.alu_op[OP_MODU:OP_DIV];
  assign es_ready_go_s  = ~(es_valid_r & es_is_div_s & ~div_done_r);
  assign es_allowin     = ~es_valid_r | (es_ready_go_s & ms_allowin);
  assign es_to_ms_valid = es_valid_r & es_ready_go_s;

  // Pipeline valid and instruction register
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_r <= 1'b0;
      es_bus_r   <= '{default: 1'b0};
    end else if (es_allowin) begin
      es_valid_r <= ds_to_es_valid;
      if (ds_to_es_valid) begin
        es_bus_r <= ds_to_es_bus;
      end else begin
        es_bus_r <= es_bus_r;
      end
    end else begin
      es_valid_r <= es_valid_r;
      es_bus_r   <= es_bus_r;
    end
  end

  // Masking the divide bits once done keeps the divider from restarting
  always_comb begin
    alu_op_s = 19'd0;
    if (!es_valid_r) begin
      alu_op_s = 19'd0;
    end else if (div_done_r) begin
      alu_op_s = {4'b0000, es_bus_r.alu_op[OP_MULHU:OP_ADD]};
    end else begin
      alu_op_s = es_bus_r.alu_op;
    end
  end

  alu u_alu (
    .clk        (clk),
    .reset      (reset),
    .alu_op     (alu_op_s),
    .alu_src1   (es_bus_r.alu_src1),
    .alu_src2   (es_bus_r.alu_src2),
    .alu_result (alu_result_s),
    .div_delay  (div_delay_s)
  );

  // Divide completion flag and held result, released when MEM takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      div_done_r   <= 1'b0;
      div_result_r <= 32'd0;
    end else if (es_to_ms_valid && ms_allowin) begin
      div_done_r   <= 1'b0;
      div_result_r <= div_result_r;
    end else if (es_valid_r && es_is_div_s && !div_done_r && (div_delay_s == 6'd0)) begin
      div_done_r   <= 1'b1;
      div_result_r <= alu_result_s;
    end else begin
      div_done_r   <= div_done_r;
      div_result_r <= div_result_r;
    end
  end

  assign es_result_s = div_done_r ? div_result_r : alu_result_s;

  es_store_gen u_store_gen (
    .mem_we    (es_bus_r.mem_we),
    .mem_size  (es_bus_r.mem_size),
    .addr_low  (es_result_s[1:0]),
    .rkd_value (es_bus_r.rkd_value),
    .we        (data_sram_we),
    .wdata     (data_sram_wdata)
  );

  assign data_sram_en   = es_valid_r & (es_bus_r.mem_we | es_bus_r.res_from_mem)
                        & es_ready_go_s & ms_allowin;
  assign data_sram_addr = es_result_s;

  assign es_to_ms_s.pc           = es_bus_r.pc;
  assign es_to_ms_s.es_result    = es_result_s;
  assign es_to_ms_s.dest         = es_bus_r.dest;
  assign es_to_ms_s.gr_we        = es_bus_r.gr_we;
  assign es_to_ms_s.res_from_mem = es_bus_r.res_from_mem;
  assign es_to_ms_s.mem_size     = es_bus_r.mem_size;
  assign es_to_ms_s.load_sign    = es_bus_r.load_sign;
  assign es_to_ms_s.addr_low     = es_result_s[1:0];
  assign es_to_ms_bus            = es_to_ms_s;

  assign es_fwd_valid   = es_valid_r & es_bus_r.gr_we & (es_bus_r.dest != 5'd0);
  assign es_fwd_is_load = es_bus_r.res_from_mem;
  assign es_fwd_dest    = es_bus_r.dest;
  assign es_fwd_data    = es_result_s;

endmodule
